// File: rtl/axi_arb_pkg.sv
`default_nettype none
// ============================================================================
// axi_arb_pkg : shared constants, payload field offsets and FSM encoding for
//               the two-port AXI read arbiter.
// Revision    : 1.0
// ============================================================================
package axi_arb_pkg;

  localparam int AXI_ID_WIDTH_DEF     = 3;
  localparam int AR_PAYLOAD_WIDTH_DEF = 61;
  localparam int R_PAYLOAD_WIDTH_DEF  = 73;
  localparam int MAX_OUTSTANDING_DEF  = 4;

  // AR payload layout, LSB first; the default configuration carries no user bits
  localparam int AR_QOS_LSB    = 0;
  localparam int AR_CACHE_LSB  = 4;
  localparam int AR_LOCK_LSB   = 8;
  localparam int AR_BURST_LSB  = 9;
  localparam int AR_SIZE_LSB   = 11;
  localparam int AR_LEN_LSB    = 14;
  localparam int AR_REGION_LSB = 22;
  localparam int AR_PROT_LSB   = 26;
  localparam int AR_ADDR_LSB   = 29;

  // R payload layout, LSB first
  localparam int R_LAST_BIT = 0;
  localparam int R_RESP_LSB = 1;
  localparam int R_DATA_LSB = 3;
  localparam int R_USER_LSB = 67;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_outstanding_cnt.sv
`default_nettype none
// ============================================================================
// axi_outstanding_cnt : saturating up/down counter of in-flight read bursts.
// Revision            : 1.0
// ============================================================================
module axi_outstanding_cnt #(
  parameter int MAX = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       inc,
  input  logic                       dec,
  output logic [$clog2(MAX+1)-1:0]   count,
  output logic                       at_max
);

  localparam int CW = $clog2(MAX + 1);

  assign at_max = (count == CW'(MAX));

  // Simultaneous inc and dec cancel; both directions saturate.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (inc && !dec) begin
      if (!at_max) count <= count + CW'(1);
    end else if (dec && !inc) begin
      if (count != '0) count <= count - CW'(1);
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni) begin
      a_no_underflow: assert (!(dec && !inc && (count == '0)));
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// axi_read_arbiter : round-robin sharing of one AXI read channel between two
//                    masters, with ID-based R routing and outstanding limits.
// Revision         : 1.0
// ============================================================================
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int AXI_ID_WIDTH     = AXI_ID_WIDTH_DEF,
  parameter int AR_PAYLOAD_WIDTH = AR_PAYLOAD_WIDTH_DEF,
  parameter int R_PAYLOAD_WIDTH  = R_PAYLOAD_WIDTH_DEF,
  parameter int MAX_OUTSTANDING  = MAX_OUTSTANDING_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,

  input  logic                          s0_ar_valid_i,
  input  logic [AR_PAYLOAD_WIDTH-1:0]   s0_ar_payload_i,
  input  logic [AXI_ID_WIDTH-1:0]       s0_ar_id_i,
  output logic                          s0_ar_ready_o,
  input  logic                          s1_ar_valid_i,
  input  logic [AR_PAYLOAD_WIDTH-1:0]   s1_ar_payload_i,
  input  logic [AXI_ID_WIDTH-1:0]       s1_ar_id_i,
  output logic                          s1_ar_ready_o,

  output logic                          s0_r_valid_o,
  output logic [R_PAYLOAD_WIDTH-1:0]    s0_r_payload_o,
  output logic [AXI_ID_WIDTH-1:0]       s0_r_id_o,
  input  logic                          s0_r_ready_i,
  output logic                          s1_r_valid_o,
  output logic [R_PAYLOAD_WIDTH-1:0]    s1_r_payload_o,
  output logic [AXI_ID_WIDTH-1:0]       s1_r_id_o,
  input  logic                          s1_r_ready_i,

  output logic                          m_ar_valid_o,
  output logic [AR_PAYLOAD_WIDTH-1:0]   m_ar_payload_o,
  output logic [AXI_ID_WIDTH:0]         m_ar_id_o,
  input  logic                          m_ar_ready_i,

  input  logic                          m_r_valid_i,
  input  logic [R_PAYLOAD_WIDTH-1:0]    m_r_payload_i,
  input  logic [AXI_ID_WIDTH:0]         m_r_id_i,
  output logic                          m_r_ready_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_state_e                  state;
  arb_state_e                  state_next;
  logic                        prio_p1;     // 1: port 1 wins a tie
  logic [AR_PAYLOAD_WIDTH-1:0] ar_payload_q;
  logic [AXI_ID_WIDTH:0]       ar_id_q;

  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic             at_max0;
  logic             at_max1;

  logic elig0;
  logic elig1;
  logic grant0;
  logic grant1;
  logic ar_hs;
  logic inc0;
  logic inc1;
  logic r_sel;
  logic r_hs_last;
  logic dec0;
  logic dec1;

  // ---------------------------------------------------------------- AR arbitration
  assign elig0  = s0_ar_valid_i && !at_max0;
  assign elig1  = s1_ar_valid_i && !at_max1;
  assign grant0 = (state == IDLE) && elig0 && (!elig1 || !prio_p1);
  assign grant1 = (state == IDLE) && elig1 && (!elig0 ||  prio_p1);
  assign ar_hs  = (state == BUSY) && m_ar_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant0 || grant1) state_next = BUSY;
      BUSY:    if (m_ar_ready_i)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s0_ar_ready_o = 1'b0;
    s1_ar_ready_o = 1'b0;
    m_ar_valid_o  = 1'b0;
    case (state)
      IDLE: begin
        s0_ar_ready_o = grant0;
        s1_ar_ready_o = grant1;
      end
      BUSY:    m_ar_valid_o = 1'b1;
      default: m_ar_valid_o = 1'b0;
    endcase
  end

  // The source port is prepended to the ID so responses can be steered back.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_p1      <= 1'b0;
      ar_payload_q <= '0;
      ar_id_q      <= '0;
    end else if (grant0 || grant1) begin
      prio_p1      <= grant0;
      ar_payload_q <= grant1 ? s1_ar_payload_i : s0_ar_payload_i;
      ar_id_q      <= grant1 ? {1'b1, s1_ar_id_i} : {1'b0, s0_ar_id_i};
    end
  end

  assign m_ar_payload_o = ar_payload_q;
  assign m_ar_id_o      = ar_id_q;

  // ---------------------------------------------------------------- R routing
  assign r_sel          = m_r_id_i[AXI_ID_WIDTH];
  assign s0_r_valid_o   = m_r_valid_i && !r_sel;
  assign s1_r_valid_o   = m_r_valid_i &&  r_sel;
  assign s0_r_payload_o = m_r_payload_i;
  assign s1_r_payload_o = m_r_payload_i;
  assign s0_r_id_o      = m_r_id_i[AXI_ID_WIDTH-1:0];
  assign s1_r_id_o      = m_r_id_i[AXI_ID_WIDTH-1:0];
  assign m_r_ready_o    = r_sel ? s1_r_ready_i : s0_r_ready_i;

  // ---------------------------------------------------------------- outstanding tracking
  assign inc0      = ar_hs && !ar_id_q[AXI_ID_WIDTH];
  assign inc1      = ar_hs &&  ar_id_q[AXI_ID_WIDTH];
  assign r_hs_last = m_r_valid_i && m_r_ready_o && m_r_payload_i[R_LAST_BIT];
  assign dec0      = r_hs_last && !r_sel;
  assign dec1      = r_hs_last &&  r_sel;

  axi_outstanding_cnt #(
    .MAX    (MAX_OUTSTANDING)
  ) u_cnt0 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc    (inc0),
    .dec    (dec0),
    .count  (cnt0),
    .at_max (at_max0)
  );

  axi_outstanding_cnt #(
    .MAX    (MAX_OUTSTANDING)
  ) u_cnt1 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc    (inc1),
    .dec    (dec1),
    .count  (cnt1),
    .at_max (at_max1)
  );

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni) begin
      a_cnt_bound: assert ((cnt0 <= CNT_W'(MAX_OUTSTANDING)) &&
                           (cnt1 <= CNT_W'(MAX_OUTSTANDING)));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// tb_axi_read_arbiter : directed stimulus with an AR-channel scoreboard.
// Revision            : 1.0
// ============================================================================
module tb_axi_read_arbiter;
  import axi_arb_pkg::*;

  localparam int IDW  = 3;
  localparam int ARW  = 61;
  localparam int RW   = 73;
  localparam int MAXO = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           s0_ar_valid, s1_ar_valid, s0_ar_ready, s1_ar_ready;
  logic [ARW-1:0] s0_ar_payload, s1_ar_payload;
  logic [IDW-1:0] s0_ar_id, s1_ar_id;
  logic           s0_r_valid, s1_r_valid, s0_r_ready, s1_r_ready;
  logic [RW-1:0]  s0_r_payload, s1_r_payload;
  logic [IDW-1:0] s0_r_id, s1_r_id;
  logic           m_ar_valid, m_ar_ready;
  logic [ARW-1:0] m_ar_payload;
  logic [IDW:0]   m_ar_id;
  logic           m_r_valid, m_r_ready;
  logic [RW-1:0]  m_r_payload;
  logic [IDW:0]   m_r_id;

  typedef struct packed {
    logic [IDW:0]   id;
    logic [ARW-1:0] payload;
  } ar_t;

  ar_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  axi_read_arbiter #(
    .AXI_ID_WIDTH     (IDW),
    .AR_PAYLOAD_WIDTH (ARW),
    .R_PAYLOAD_WIDTH  (RW),
    .MAX_OUTSTANDING  (MAXO)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .s0_ar_valid_i   (s0_ar_valid),
    .s0_ar_payload_i (s0_ar_payload),
    .s0_ar_id_i      (s0_ar_id),
    .s0_ar_ready_o   (s0_ar_ready),
    .s1_ar_valid_i   (s1_ar_valid),
    .s1_ar_payload_i (s1_ar_payload),
    .s1_ar_id_i      (s1_ar_id),
    .s1_ar_ready_o   (s1_ar_ready),
    .s0_r_valid_o    (s0_r_valid),
    .s0_r_payload_o  (s0_r_payload),
    .s0_r_id_o       (s0_r_id),
    .s0_r_ready_i    (s0_r_ready),
    .s1_r_valid_o    (s1_r_valid),
    .s1_r_payload_o  (s1_r_payload),
    .s1_r_id_o       (s1_r_id),
    .s1_r_ready_i    (s1_r_ready),
    .m_ar_valid_o    (m_ar_valid),
    .m_ar_payload_o  (m_ar_payload),
    .m_ar_id_o       (m_ar_id),
    .m_ar_ready_i    (m_ar_ready),
    .m_r_valid_i     (m_r_valid),
    .m_r_payload_i   (m_r_payload),
    .m_r_id_i        (m_r_id),
    .m_r_ready_o     (m_r_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IDW:0] id, input logic [ARW-1:0] pl);
    ar_t e;
    e.id      = id;
    e.payload = pl;
    exp_q.push_back(e);
  endtask

  function automatic logic [ARW-1:0] ar_pl(input logic [31:0] addr, input logic [7:0] len);
    return (ARW'(addr) << AR_ADDR_LSB) | (ARW'(len) << AR_LEN_LSB) | (ARW'(2'b01) << AR_BURST_LSB);
  endfunction

  function automatic logic [RW-1:0] r_pl(input logic [63:0] data, input logic last);
    return (RW'(data) << R_DATA_LSB) | RW'(last);
  endfunction

  // Scoreboard monitor: every downstream AR handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && m_ar_valid && m_ar_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ar_unexpected: got id 0x%0h payload 0x%0h, expected no transfer", m_ar_id, m_ar_payload);
      end else begin
        ar_t e;
        e = exp_q.pop_front();
        check("ar_id", 128'(m_ar_id), 128'(e.id));
        check("ar_payload", 128'(m_ar_payload), 128'(e.payload));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [ARW-1:0] pa, pb, pc, pd, pe, pf;
    logic [RW-1:0]  rp;
    pa = ar_pl(32'h0000_3000, 8'd1);
    pb = ar_pl(32'h0000_4000, 8'd3);
    pc = ar_pl(32'h0000_5000, 8'd0);
    pd = ar_pl(32'h0000_6000, 8'd15);
    pe = ar_pl(32'h0000_7000, 8'd2);
    pf = ar_pl(32'h0000_8000, 8'd4);

    s0_ar_valid = 0; s0_ar_payload = '0; s0_ar_id = '0;
    s1_ar_valid = 0; s1_ar_payload = '0; s1_ar_id = '0;
    s0_r_ready = 0; s1_r_ready = 0;
    m_ar_ready = 0; m_r_valid = 0; m_r_payload = '0; m_r_id = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_ar_valid", 128'(m_ar_valid), 128'(0));
    check("rst_s0_ar_ready", 128'(s0_ar_ready), 128'(0));
    check("rst_s1_ar_ready", 128'(s1_ar_ready), 128'(0));
    check("rst_m_ar_id", 128'(m_ar_id), 128'(0));
    check("rst_m_ar_payload", 128'(m_ar_payload), 128'(0));
    check("rst_cnt0", 128'(dut.u_cnt0.count), 128'(0));
    check("rst_cnt1", 128'(dut.u_cnt1.count), 128'(0));
    step();
    rst_n = 1;

    // Single request from port 0
    step();
    s0_ar_valid = 1; s0_ar_id = 3'd5; s0_ar_payload = ar_pl(32'h0000_1000, 8'd0);
    @(negedge clk);
    check("single_s0_ready", 128'(s0_ar_ready), 128'(1));
    check("single_s1_ready", 128'(s1_ar_ready), 128'(0));
    check("single_m_valid_c0", 128'(m_ar_valid), 128'(0));
    push(4'h5, ar_pl(32'h0000_1000, 8'd0));
    step();
    s0_ar_valid = 0;
    @(negedge clk);
    check("single_m_valid_c1", 128'(m_ar_valid), 128'(1));
    check("single_m_id_c1", 128'(m_ar_id), 128'(4'h5));
    step();
    m_ar_ready = 1;
    @(negedge clk);
    step();
    m_ar_ready = 0;
    @(negedge clk);
    check("single_m_valid_done", 128'(m_ar_valid), 128'(0));
    check("single_cnt0", 128'(dut.u_cnt0.count), 128'(1));

    // Backpressure on the downstream AR channel
    step();
    s1_ar_valid = 1; s1_ar_id = 3'd3; s1_ar_payload = pf;
    @(negedge clk);
    check("bp_s1_ready", 128'(s1_ar_ready), 128'(1));
    push(4'hB, pf);
    step();
    s0_ar_valid = 1; s0_ar_id = 3'd1; s0_ar_payload = pa;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_m_valid", 128'(m_ar_valid), 128'(1));
      check("bp_m_id", 128'(m_ar_id), 128'(4'hB));
      check("bp_m_payload", 128'(m_ar_payload), 128'(pf));
      check("bp_s0_ready", 128'(s0_ar_ready), 128'(0));
      check("bp_s1_ready", 128'(s1_ar_ready), 128'(0));
      step();
    end
    m_ar_ready = 1; s0_ar_valid = 0; s1_ar_valid = 0;
    @(negedge clk);
    step();
    m_ar_ready = 0;
    @(negedge clk);
    check("bp_m_valid_done", 128'(m_ar_valid), 128'(0));
    check("bp_cnt1", 128'(dut.u_cnt1.count), 128'(1));

    // Contention: both ports valid, downstream always ready -> 0,1,0,1
    step();
    s0_ar_valid = 1; s0_ar_id = 3'd1; s0_ar_payload = pa;
    s1_ar_valid = 1; s1_ar_id = 3'd2; s1_ar_payload = pb;
    m_ar_ready = 1;
    push(4'h1, pa); push(4'hA, pb); push(4'h1, pa); push(4'hA, pb);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i % 2 == 0) begin
        check("rr_s0_ready", 128'(s0_ar_ready), 128'(i % 4 == 0));
        check("rr_s1_ready", 128'(s1_ar_ready), 128'(i % 4 == 2));
      end else begin
        check("rr_m_valid", 128'(m_ar_valid), 128'(1));
      end
      step();
    end
    s0_ar_valid = 0; s1_ar_valid = 0; m_ar_ready = 0;
    @(negedge clk);
    check("rr_cnt0", 128'(dut.u_cnt0.count), 128'(3));
    check("rr_cnt1", 128'(dut.u_cnt1.count), 128'(3));

    // Reset asserted while BUSY
    step();
    s0_ar_valid = 1; s0_ar_id = 3'd6; s0_ar_payload = pc;
    @(negedge clk);
    check("mrst_s0_ready", 128'(s0_ar_ready), 128'(1));
    step();
    s0_ar_valid = 0;
    @(negedge clk);
    check("mrst_m_valid_before", 128'(m_ar_valid), 128'(1));
    #1 rst_n = 0;
    #1;
    check("mrst_m_valid", 128'(m_ar_valid), 128'(0));
    check("mrst_m_id", 128'(m_ar_id), 128'(0));
    check("mrst_cnt0", 128'(dut.u_cnt0.count), 128'(0));
    check("mrst_cnt1", 128'(dut.u_cnt1.count), 128'(0));
    step();
    rst_n = 1;
    s0_ar_valid = 1; s0_ar_id = 3'd1; s0_ar_payload = pa;
    s1_ar_valid = 1; s1_ar_id = 3'd2; s1_ar_payload = pb;
    @(negedge clk);
    check("mrst_prio_s0", 128'(s0_ar_ready), 128'(1));
    check("mrst_prio_s1", 128'(s1_ar_ready), 128'(0));
    push(4'h1, pa);
    step();
    s0_ar_valid = 0; s1_ar_valid = 0; m_ar_ready = 1;
    @(negedge clk);
    step();
    m_ar_ready = 0;
    @(negedge clk);
    check("mrst_cnt0_after", 128'(dut.u_cnt0.count), 128'(1));

    // Outstanding limit on port 1
    step();
    s1_ar_valid = 1; s1_ar_id = 3'd4; s1_ar_payload = pd; m_ar_ready = 1;
    for (int i = 0; i < 4; i++) push(4'hC, pd);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i % 2 == 0) check("lim_s1_ready", 128'(s1_ar_ready), 128'(1));
      step();
    end
    s0_ar_valid = 1; s0_ar_id = 3'd7; s0_ar_payload = pe;
    @(negedge clk);
    check("lim_cnt1_max", 128'(dut.u_cnt1.count), 128'(4));
    check("lim_s1_stall", 128'(s1_ar_ready), 128'(0));
    check("lim_s0_grant", 128'(s0_ar_ready), 128'(1));
    push(4'h7, pe);
    step();
    s0_ar_valid = 0;
    @(negedge clk);
    step();
    @(negedge clk);
    check("lim_s1_stall2", 128'(s1_ar_ready), 128'(0));
    check("lim_m_valid_idle", 128'(m_ar_valid), 128'(0));
    step();
    m_r_valid = 1; m_r_id = 4'b1000; m_r_payload = r_pl(64'h1111_2222_3333_4444, 1'b1); s1_r_ready = 1;
    @(negedge clk);
    check("lim_r_s1_valid", 128'(s1_r_valid), 128'(1));
    check("lim_r_m_ready", 128'(m_r_ready), 128'(1));
    step();
    m_r_valid = 0; s1_r_ready = 0;
    @(negedge clk);
    check("lim_cnt1_dec", 128'(dut.u_cnt1.count), 128'(3));
    check("lim_s1_regrant", 128'(s1_ar_ready), 128'(1));
    push(4'hC, pd);
    step();
    s1_ar_valid = 0;
    @(negedge clk);
    step();
    m_ar_ready = 0;

    // R routing to port 1 with backpressure, non-last beat
    rp = r_pl(64'hDEAD_BEEF_0BAD_F00D, 1'b0);
    m_r_valid = 1; m_r_id = 4'b1010; m_r_payload = rp; s1_r_ready = 0; s0_r_ready = 1;
    #1;
    check("r1_s1_valid", 128'(s1_r_valid), 128'(1));
    check("r1_s0_valid", 128'(s0_r_valid), 128'(0));
    check("r1_s1_id", 128'(s1_r_id), 128'(3'b010));
    check("r1_m_ready", 128'(m_r_ready), 128'(0));
    check("r1_s0_payload", 128'(s0_r_payload), 128'(rp));
    check("r1_s1_payload", 128'(s1_r_payload), 128'(rp));
    s1_r_ready = 1;
    #1;
    check("r1_m_ready_on", 128'(m_r_ready), 128'(1));
    step();
    m_r_valid = 0; s0_r_ready = 0; s1_r_ready = 0;
    @(negedge clk);
    check("r1_cnt1_nonlast", 128'(dut.u_cnt1.count), 128'(4));
    check("r1_cnt0_nonlast", 128'(dut.u_cnt0.count), 128'(2));

    // R routing to port 0, last beat
    step();
    m_r_valid = 1; m_r_id = 4'b0111; m_r_payload = r_pl(64'h5, 1'b1); s0_r_ready = 1; s1_r_ready = 0;
    @(negedge clk);
    check("r0_s0_valid", 128'(s0_r_valid), 128'(1));
    check("r0_s1_valid", 128'(s1_r_valid), 128'(0));
    check("r0_s0_id", 128'(s0_r_id), 128'(3'b111));
    check("r0_m_ready", 128'(m_r_ready), 128'(1));
    step();
    m_r_valid = 0; s0_r_ready = 0;
    @(negedge clk);
    check("r0_cnt0_dec", 128'(dut.u_cnt0.count), 128'(1));

    // Same-cycle increment and decrement on port 0
    step();
    s0_ar_valid = 1; s0_ar_id = 3'd2; s0_ar_payload = pa;
    @(negedge clk);
    check("incdec_s0_ready", 128'(s0_ar_ready), 128'(1));
    push(4'h2, pa);
    step();
    s0_ar_valid = 0; m_ar_ready = 1;
    m_r_valid = 1; m_r_id = 4'b0000; m_r_payload = r_pl(64'h9, 1'b1); s0_r_ready = 1;
    @(negedge clk);
    step();
    m_ar_ready = 0; m_r_valid = 0; s0_r_ready = 0;
    @(negedge clk);
    check("incdec_cnt0", 128'(dut.u_cnt0.count), 128'(1));

    step();
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
